// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared encodings for the BIP run controller
package bip_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 32;

    // Opcode occupies the top five bits of an instruction word
    localparam int OPC_HI = DEF_DATA_W - 1;
    localparam int OPC_LO = DEF_DATA_W - 5;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] OPC_HLT = 5'b00000;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_ABORT = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bip_run_controller_if.sv
// rtl/bip_run_controller_if.sv - command, load stream, imem and core signals
interface bip_run_controller_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
);
    logic              cmd_valid;
    logic [1:0]        cmd_code;
    logic              cmd_ready;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_w_addr;
    logic [DATA_W-1:0] imem_w_data;
    logic [4:0]        opcode;
    logic              pc_en;
    logic              cpu_clr;
    logic              busy;
    logic              halted;
    logic              cmd_err;
    logic [ADDR_W:0]   prog_len;
    logic [CNT_W-1:0]  instr_count;

    // Host/core side
    modport master (
        output cmd_valid, cmd_code, load_valid, load_data, load_last, opcode,
        input  cmd_ready, load_ready, imem_wr_en, imem_w_addr, imem_w_data,
               pc_en, cpu_clr, busy, halted, cmd_err, prog_len, instr_count
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_code, load_valid, load_data, load_last, opcode,
        output cmd_ready, load_ready, imem_wr_en, imem_w_addr, imem_w_data,
               pc_en, cpu_clr, busy, halted, cmd_err, prog_len, instr_count
    );
endinterface

// File: rtl/bip_load_ctrl.sv
// rtl/bip_load_ctrl.sv - program load write-address counter and length capture
module bip_load_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_active,
    input  logic              i_abort,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_done,
    output logic [ADDR_W:0]   o_prog_len
);
    logic [ADDR_W:0] r_cnt;
    logic [ADDR_W:0] r_prog_len;
    logic            w_full;

    // An abort in the same cycle as a word drops that word
    assign o_ready    = i_active;
    assign o_wr_en    = i_active & i_valid & ~i_abort;
    assign o_w_addr   = r_cnt[ADDR_W-1:0];
    assign w_full     = &r_cnt[ADDR_W-1:0];
    assign o_done     = o_wr_en & (i_last | w_full);
    assign o_prog_len = r_prog_len;

    // Write address advances per word; length is latched when the load ends
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt      <= '0;
            r_prog_len <= '0;
        end else begin
            if (i_start) begin
                r_cnt <= '0;
            end else if (o_wr_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (o_done) begin
                r_prog_len <= r_cnt + 1'b1;
            end else if (i_active && i_abort) begin
                r_prog_len <= r_cnt;
            end
        end
    end
endmodule

// File: rtl/bip_run_controller.sv
// rtl/bip_run_controller.sv - load/run/step sequencer for the BIP core
module bip_run_controller
    import bip_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    bip_run_controller_if.slave  io_bus
);
    state_e           r_state;
    state_e           w_next;
    logic             r_cpu_clr;
    logic             r_run_pend;
    logic             r_cmd_err;
    logic [CNT_W-1:0] r_count;
    logic             w_clr_req;
    logic             w_run_pend_nxt;
    logic             w_err_set;
    logic             w_err_clr;
    logic             w_load_start;
    logic             w_pc_en;
    logic             w_abort;
    logic             w_hlt;
    logic             w_load_done;

    assign w_abort = io_bus.cmd_valid & (io_bus.cmd_code == CMD_ABORT);
    assign w_hlt   = (io_bus.opcode[OPC_W-1:0] == OPC_HLT);

    bip_load_ctrl #(.ADDR_W(ADDR_W)) u_load (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_load_start),
        .i_active   (r_state == ST_LOAD),
        .i_abort    (w_abort),
        .i_valid    (io_bus.load_valid),
        .i_last     (io_bus.load_last),
        .o_ready    (io_bus.load_ready),
        .o_wr_en    (io_bus.imem_wr_en),
        .o_w_addr   (io_bus.imem_w_addr),
        .o_done     (w_load_done),
        .o_prog_len (io_bus.prog_len)
    );

    // Next-state, pc_en and command legality
    always_comb begin
        w_next         = r_state;
        w_pc_en        = 1'b0;
        w_clr_req      = 1'b0;
        w_run_pend_nxt = 1'b0;
        w_err_set      = 1'b0;
        w_err_clr      = 1'b0;
        w_load_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.cmd_valid) begin
                    case (io_bus.cmd_code)
                        CMD_LOAD: begin
                            w_next       = ST_LOAD;
                            w_clr_req    = 1'b1;
                            w_err_clr    = 1'b1;
                            w_load_start = 1'b1;
                        end
                        CMD_RUN:  w_next = ST_RUN;
                        CMD_STEP: w_next = ST_STEP;
                        default:  w_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_err_set = io_bus.cmd_valid;
                    if (w_load_done) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_RUN, ST_STEP: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_err_set = io_bus.cmd_valid;
                    if (w_hlt) begin
                        w_next = ST_DONE;
                    end else begin
                        w_pc_en = 1'b1;
                        if (r_state == ST_STEP) begin
                            w_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_DONE: begin
                // A restart holds DONE for the clear cycle so pc_en never meets cpu_clr
                if (r_run_pend) begin
                    if (w_abort) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_err_set = io_bus.cmd_valid;
                        w_next    = ST_RUN;
                    end
                end else if (io_bus.cmd_valid) begin
                    case (io_bus.cmd_code)
                        CMD_LOAD: begin
                            w_next       = ST_LOAD;
                            w_clr_req    = 1'b1;
                            w_err_clr    = 1'b1;
                            w_load_start = 1'b1;
                        end
                        CMD_RUN: begin
                            w_clr_req      = 1'b1;
                            w_run_pend_nxt = 1'b1;
                        end
                        CMD_STEP: w_err_set = 1'b1;
                        default:  w_next    = ST_IDLE;
                    endcase
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, clear pulse, error flag and executed-instruction counter
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_cpu_clr  <= 1'b0;
            r_run_pend <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next;
            r_cpu_clr  <= w_clr_req;
            r_run_pend <= w_run_pend_nxt;
            if (w_err_clr) begin
                r_cmd_err <= 1'b0;
            end else if (w_err_set) begin
                r_cmd_err <= 1'b1;
            end
            if (r_cpu_clr) begin
                r_count <= '0;
            end else if (w_pc_en && !(&r_count)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign io_bus.cmd_ready   = 1'b1;
    assign io_bus.imem_w_data = io_bus.load_data;
    assign io_bus.pc_en       = w_pc_en;
    assign io_bus.cpu_clr     = r_cpu_clr;
    assign io_bus.busy        = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_STEP);
    assign io_bus.halted      = (r_state == ST_DONE);
    assign io_bus.cmd_err     = r_cmd_err;
    assign io_bus.instr_count = r_count;
endmodule

// File: tb/tb_bip_run_controller.sv
// tb/tb_bip_run_controller.sv - directed bench with imem write scoreboard and core model
module tb_bip_run_controller;
    import bip_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pc_en_cnt = 0;
    int   clr_cnt = 0;
    int   wa = 0;
    wr_t  exp_q[$];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] pc = '0;

    bip_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    bip_run_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.opcode = mem[pc][OPC_HI:OPC_LO];

    always @(posedge clk) begin
        if (bus.imem_wr_en) mem[bus.imem_w_addr] <= bus.imem_w_data;
        if (bus.cpu_clr) pc <= '0;
        else if (bus.pc_en) pc <= pc + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.pc_en) pc_en_cnt++;
        if (bus.cpu_clr) clr_cnt++;
        check("pc_en_cpu_clr_excl", {31'd0, bus.pc_en & bus.cpu_clr}, 32'd0);
        if (bus.imem_wr_en) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL wr_unexpected: observed addr=%0h data=%0h expected no write",
                       bus.imem_w_addr, bus.imem_w_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_w_addr), 32'(e.a));
                check("wr_data", 32'(bus.imem_w_data), 32'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = c;
        if (c == CMD_LOAD) wa = 0;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic stream_word(input logic [DATA_W-1:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        exp_q.push_back('{a: ADDR_W'(wa), d: d});
        wa++;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!bus.halted && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic load_prog();
        int c0;
        c0 = clr_cnt;
        send_cmd(CMD_LOAD);
        check("load_cpu_clr", {31'd0, bus.cpu_clr}, 32'd1);
        check("load_ready", {31'd0, bus.load_ready}, 32'd1);
        stream_word(16'h0801, 1'b0);
        stream_word(16'h1002, 1'b0);
        stream_word(16'h1803, 1'b0);
        stream_word(16'h0000, 1'b1);
        check("load_exit_busy", {31'd0, bus.busy}, 32'd0);
        check("load_prog_len", 32'(bus.prog_len), 32'd4);
        check("load_clr_pulses", 32'(clr_cnt - c0), 32'd1);
    endtask

    initial begin
        int n;
        int p0;
        int c0;
        logic [4:0] op;
        bus.cmd_valid  = 1'b0;
        bus.cmd_code   = 2'b00;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        #1;
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_cpu_clr", {31'd0, bus.cpu_clr}, 32'd0);
        check("rst_prog_len", 32'(bus.prog_len), 32'd0);
        check("rst_instr_count", bus.instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: load a four-word program
        load_prog();

        // 2: run to HLT
        p0 = pc_en_cnt;
        send_cmd(CMD_RUN);
        check("run_busy", {31'd0, bus.busy}, 32'd1);
        wait_halt(n);
        check("run_halt_latency", 32'(n), 32'd4);
        check("run_halted", {31'd0, bus.halted}, 32'd1);
        check("run_pc_en_cycles", 32'(pc_en_cnt - p0), 32'd3);
        check("run_instr_count", bus.instr_count, 32'd3);

        // 3: single steps after a reload
        send_cmd(CMD_ABORT);
        check("abort_done_idle", {31'd0, bus.halted | bus.busy}, 32'd0);
        load_prog();
        for (int k = 1; k <= 3; k++) begin
            send_cmd(CMD_STEP);
            check("step_pc_en", {31'd0, bus.pc_en}, 32'd1);
            tick();
            check("step_count", bus.instr_count, 32'(k));
            check("step_idle", {31'd0, bus.busy}, 32'd0);
        end
        send_cmd(CMD_STEP);
        check("step_hlt_pc_en", {31'd0, bus.pc_en}, 32'd0);
        tick();
        check("step_hlt_halted", {31'd0, bus.halted}, 32'd1);
        check("step_hlt_count", bus.instr_count, 32'd3);

        // 4: restart from DONE
        c0 = clr_cnt;
        p0 = pc_en_cnt;
        send_cmd(CMD_RUN);
        check("rerun_cpu_clr", {31'd0, bus.cpu_clr}, 32'd1);
        tick();
        check("rerun_cpu_clr_off", {31'd0, bus.cpu_clr}, 32'd0);
        check("rerun_count_zero", bus.instr_count, 32'd0);
        check("rerun_busy", {31'd0, bus.busy}, 32'd1);
        wait_halt(n);
        check("rerun_halt_latency", 32'(n), 32'd4);
        check("rerun_count", bus.instr_count, 32'd3);
        check("rerun_pc_en_cycles", 32'(pc_en_cnt - p0), 32'd3);
        check("rerun_clr_pulses", 32'(clr_cnt - c0), 32'd1);

        // 5: abort during load, then an illegal command in LOAD
        send_cmd(CMD_ABORT);
        send_cmd(CMD_LOAD);
        check("err_after_load", {31'd0, bus.cmd_err}, 32'd0);
        stream_word(16'h2000, 1'b0);
        stream_word(16'h2001, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h2002;
        bus.cmd_valid  = 1'b1;
        bus.cmd_code   = CMD_ABORT;
        tick();
        bus.load_valid = 1'b0;
        bus.cmd_valid  = 1'b0;
        check("abort_load_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_prog_len", 32'(bus.prog_len), 32'd2);
        send_cmd(CMD_LOAD);
        send_cmd(CMD_STEP);
        check("step_in_load_err", {31'd0, bus.cmd_err}, 32'd1);
        check("step_in_load_busy", {31'd0, bus.busy}, 32'd1);
        send_cmd(CMD_ABORT);
        check("err_sticky", {31'd0, bus.cmd_err}, 32'd1);
        send_cmd(CMD_LOAD);
        check("err_cleared_by_load", {31'd0, bus.cmd_err}, 32'd0);
        send_cmd(CMD_ABORT);

        // 6: full memory load, then reset during RUN
        send_cmd(CMD_LOAD);
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            op = 5'(1 + (i % 30));
            stream_word({op, 11'(i)}, 1'b0);
        end
        check("full_exit_busy", {31'd0, bus.busy}, 32'd0);
        check("full_prog_len", 32'(bus.prog_len), 32'd2048);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hFFFF;
        tick();
        bus.load_valid = 1'b0;
        check("full_no_wrap_queue", 32'(exp_q.size()), 32'd0);
        send_cmd(CMD_RUN);
        repeat (5) tick();
        check("big_run_pc_en", {31'd0, bus.pc_en}, 32'd1);
        check("big_run_count", bus.instr_count, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_pc_en", {31'd0, bus.pc_en}, 32'd0);
        check("arst_halted", {31'd0, bus.halted}, 32'd0);
        check("arst_count", bus.instr_count, 32'd0);
        check("arst_prog_len", 32'(bus.prog_len), 32'd0);
        check("arst_load_ready", {31'd0, bus.load_ready}, 32'd0);
        check("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, bus.busy | bus.halted}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bip_run_controller.md
Name: bip_run_controller

Overview:
Sequencer for the BIP-style processor core (program counter, instruction memory, opcode decoder).
- Loads a program into instruction memory through a valid/ready word stream.
- Runs the program to completion (HLT opcode) or single-steps it one instruction per command.
- Drives the PC enable and a synchronous core clear, and counts executed instructions.
- Sits between the host/UART command front-end and the control/datapath core.

Parameters:
ADDR_W, 11, instruction memory address width (PC width)
DATA_W, 16, instruction word width (opcode = top 5 bits)
CNT_W, 32, executed-instruction counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command strobe
cmd_code  in  2  00=LOAD, 01=RUN, 10=STEP, 11=ABORT
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
load_valid  in  1  program word valid
load_data  in  DATA_W  program word
load_last  in  1  marks final program word
load_ready  out  1  controller accepts a word this cycle
imem_wr_en  out  1  instruction memory write enable
imem_w_addr  out  ADDR_W  instruction memory write address
imem_w_data  out  DATA_W  instruction memory write data
opcode  in  5  opcode of word at current PC (combinational read)
pc_en  out  1  program counter increment enable
cpu_clr  out  1  one-cycle synchronous clear of PC and accumulator
busy  out  1  state is LOAD, RUN or STEP
halted  out  1  state is DONE
cmd_err  out  1  sticky: command illegal in current state was received
prog_len  out  ADDR_W+1  number of words written by last completed LOAD
instr_count  out  CNT_W  instructions executed since last cpu_clr

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0 except cmd_ready=1; counters, prog_len and write address cleared.
- cmd_ready=1 in every state. Commands illegal in the current state are consumed and ignored, and set cmd_err. cmd_err clears only on LOAD acceptance.
- States: IDLE, LOAD, RUN, STEP, DONE.
- IDLE:
  - LOAD -> LOAD, with cpu_clr pulsed and write address set to 0.
  - RUN -> RUN, continuing from the current PC with no clear.
  - STEP -> STEP.
  - ABORT is legal and does nothing.
- LOAD:
  - load_ready=1.
  - Each load_valid&load_ready cycle: imem_wr_en=1, imem_w_addr=write address, imem_w_data=load_data (combinational pass-through); write address increments.
  - Exit to IDLE after the word with load_last=1, or after writing address 2^ADDR_W-1 (no wrap). prog_len = words written.
  - ABORT -> IDLE. If it coincides with load_valid, that word is not written. prog_len keeps the count of words written so far.
  - RUN and STEP are illegal here.
- RUN:
  - opcode != 5'b00000: pc_en=1 and instr_count increments (saturating at all-ones).
  - opcode == 5'b00000 (HLT): pc_en=0 in that cycle and next state is DONE. HLT is not counted.
  - ABORT -> IDLE with pc_en=0 in that cycle; PC is kept.
- STEP:
  - Exactly one cycle. If opcode != HLT: pc_en=1, count increments, -> IDLE. If opcode == HLT: pc_en=0, -> DONE.
  - Commands arriving in STEP are illegal, except ABORT. ABORT wins over the step: pc_en=0, -> IDLE.
- DONE:
  - halted=1.
  - RUN pulses cpu_clr (PC and instr_count to 0) and enters RUN the next cycle.
  - LOAD behaves as in IDLE.
  - STEP is illegal. ABORT -> IDLE.
- Signal rules:
  - pc_en and cpu_clr are never both 1.
  - cpu_clr is registered and high for exactly one cycle.
  - pc_en is combinational from state and opcode, with no added latency.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE. Instruction memory contents are not touched.

Decomposition:
- Package bip_pkg: command encodings (CMD_LOAD/RUN/STEP/ABORT), state enum, OPC_HLT=5'b00000, and the opcode field position as DATA_W-1 : DATA_W-5.
- One natural sub-module: bip_load_ctrl, covering the LOAD-state write-address counter, the last/full detection and prog_len capture.
- FSM, counters and output logic stay in the top.

Test Plan:
1. Reset, then LOAD; stream 4 words 0x0801, 0x1002, 0x1803, 0x0000 with last on word 4. Required: writes to addresses 0..3 with that data, prog_len=4, returns to IDLE, cpu_clr pulsed once at LOAD acceptance.
2. RUN with opcodes 1,2,3 then HLT at PC 3. Required: pc_en high for exactly 3 cycles, instr_count=3, halted=1 the cycle after HLT is seen.
3. From IDLE after load, issue STEP three times. Required: each gives a single pc_en cycle, instr_count=1,2,3. A fourth STEP on HLT gives pc_en=0 and halted=1.
4. RUN issued in DONE. Required: cpu_clr for 1 cycle, instr_count=0, then re-execution giving instr_count=3 again.
5. ABORT during LOAD coincident with load_valid on word 2. Required: word 2 not written, prog_len=2, state IDLE. Next, STEP sent during LOAD sets cmd_err=1.
6. Load 2^ADDR_W words with no load_last. Required: automatic exit after address 2047, prog_len=2048, no write wrap to address 0. Async reset asserted mid-RUN clears all outputs immediately.
